// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard: tracks in-flight destination registers after decode,
// raising the load-use stall, EX operand forwarding selects, decode write-back
// bypass selects and squashing young slots on a taken branch.
module pipe_hazard_scoreboard #(
    parameter int unsigned N          = 32,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned KILL_SLOTS = 1,
    localparam int unsigned RW = $clog2(N),
    localparam int unsigned SW = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic          id_use_rs1,
    input  logic          id_use_rs2,
    input  logic [RW-1:0] id_rd,
    input  logic          id_reg_write,
    input  logic [SW-1:0] id_lat,
    output logic          stall,
    output logic [SW-1:0] fwd_a,
    output logic [SW-1:0] fwd_b,
    output logic          id_byp_a,
    output logic          id_byp_b,
    output logic          ex_valid
);

    typedef struct packed {
        logic          valid;
        logic          wr;
        logic [RW-1:0] rd;
        logic [SW-1:0] lat;
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic          use1;
        logic          use2;
    } slot_t;

    slot_t         slot_q [DEPTH];
    slot_t         slot_d [DEPTH];
    slot_t         issue_c;
    logic [SW-1:0] lat_c;
    logic          haz_a_c, haz_b_c;
    logic          hit_a_c, hit_b_c;
    logic          byp_a_c, byp_b_c;
    logic          stall_c;
    logic [SW-1:0] fwd_a_c, fwd_b_c;
    logic          fnd_a_c, fnd_b_c;

    // A slot produces a value the consumer needs for source src
    function automatic logic producer_match(input slot_t s, input logic [RW-1:0] src,
                                            input logic use_src);
        return s.valid && s.wr && (s.rd == src) && (s.rd != '0) && use_src;
    endfunction

    // Normalise result latency: 0 means ALU, anything past MEM/WB saturates
    always_comb begin
        lat_c = id_lat;
        if (id_lat == '0) begin
            lat_c = SW'(1);
        end else if (id_lat > SW'(DEPTH - 1)) begin
            lat_c = SW'(DEPTH - 1);
        end
    end

    // Payload entering slot 0 when decode issues
    always_comb begin
        issue_c       = '0;
        issue_c.valid = 1'b1;
        issue_c.wr    = id_reg_write;
        issue_c.rd    = id_rd;
        issue_c.lat   = lat_c;
        issue_c.rs1   = id_rs1;
        issue_c.rs2   = id_rs2;
        issue_c.use1  = id_use_rs1;
        issue_c.use2  = id_use_rs2;
    end

    // Decode hazard and bypass: only the youngest matching producer counts
    always_comb begin
        haz_a_c = 1'b0;
        haz_b_c = 1'b0;
        hit_a_c = 1'b0;
        hit_b_c = 1'b0;
        byp_a_c = 1'b0;
        byp_b_c = 1'b0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (!hit_a_c && producer_match(slot_q[j], id_rs1, id_use_rs1)) begin
                hit_a_c = 1'b1;
                haz_a_c = (j <= DEPTH - 2) && (j + 1 < 32'(slot_q[j].lat));
                byp_a_c = (j == DEPTH - 1);
            end
            if (!hit_b_c && producer_match(slot_q[j], id_rs2, id_use_rs2)) begin
                hit_b_c = 1'b1;
                haz_b_c = (j <= DEPTH - 2) && (j + 1 < 32'(slot_q[j].lat));
                byp_b_c = (j == DEPTH - 1);
            end
        end
        stall_c = id_valid && (haz_a_c || haz_b_c) && !flush;
    end

    // EX forwarding for the slot-0 instruction from the nearest older producer
    always_comb begin
        fwd_a_c = '0;
        fwd_b_c = '0;
        fnd_a_c = 1'b0;
        fnd_b_c = 1'b0;
        for (int unsigned j = 1; j < DEPTH; j++) begin
            if (slot_q[0].valid && !fnd_a_c &&
                producer_match(slot_q[j], slot_q[0].rs1, slot_q[0].use1)) begin
                fnd_a_c = 1'b1;
                fwd_a_c = SW'(j);
            end
            if (slot_q[0].valid && !fnd_b_c &&
                producer_match(slot_q[j], slot_q[0].rs2, slot_q[0].use2)) begin
                fnd_b_c = 1'b1;
                fwd_b_c = SW'(j);
            end
        end
    end

    // Next slot contents: shift, issue or bubble, flush kills young slots, hold freezes
    always_comb begin
        for (int unsigned j = 0; j < DEPTH; j++) begin
            slot_d[j] = slot_q[j];
        end
        if (!hold) begin
            for (int unsigned j = 1; j < DEPTH; j++) begin
                slot_d[j] = slot_q[SW'(j - 1)];
                if (flush && (j < KILL_SLOTS)) begin
                    slot_d[j] = '0;
                end
            end
            slot_d[0] = '0;
            if (id_valid && !stall_c && !flush) begin
                slot_d[0] = issue_c;
            end
        end
    end

    // Slot register with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                slot_q[j] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                slot_q[j] <= slot_d[j];
            end
        end
    end

    // Drive ports
    always_comb begin
        stall    = stall_c;
        fwd_a    = fwd_a_c;
        fwd_b    = fwd_b_c;
        id_byp_a = byp_a_c;
        id_byp_b = byp_b_c;
        ex_valid = slot_q[0].valid;
    end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench for pipe_hazard_scoreboard (DEPTH=3, KILL_SLOTS=2).
module tb_pipe_hazard_scoreboard;

    localparam int unsigned N     = 32;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned KILL  = 2;
    localparam int unsigned RW    = 5;
    localparam int unsigned SW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          hold;
    logic          flush;
    logic          id_valid;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_use_rs1, id_use_rs2, id_reg_write;
    logic [SW-1:0] id_lat;
    logic          stall, id_byp_a, id_byp_b, ex_valid;
    logic [SW-1:0] fwd_a, fwd_b;

    int checks = 0;
    int errors = 0;

    pipe_hazard_scoreboard #(.N(N), .DEPTH(DEPTH), .KILL_SLOTS(KILL)) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_lat(id_lat),
        .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .id_byp_a(id_byp_a), .id_byp_b(id_byp_b), .ex_valid(ex_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                             input logic u1, input logic u2, input logic [RW-1:0] rd,
                             input logic wr, input logic [SW-1:0] lat);
        id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = wr; id_lat = lat;
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_rd = '0; id_reg_write = 1'b0; id_lat = '0;
    endtask

    task automatic drain();
        idle();
        hold = 1'b0; flush = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        set_issue(0, 0, 0, 0, 5, 1, 1); tick();
        set_issue(5, 0, 1, 0, 6, 1, 2); tick();
        set_issue(0, 6, 0, 1, 0, 0, 1);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL pre_rst_stall got %0d exp 1", stall); end
        checks++; if (fwd_a !== 2'd1) begin errors++; $display("FAIL pre_rst_fwd_a got %0d exp 1", fwd_a); end
        rst = 1'b1; #1;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_ex_valid got %0d exp 0", ex_valid); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0d exp 0", stall); end
        checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin errors++; $display("FAIL rst_fwd got %0d/%0d exp 0/0", fwd_a, fwd_b); end
        checks++; if (id_byp_a !== 1'b0 || id_byp_b !== 1'b0) begin errors++; $display("FAIL rst_byp got %0d/%0d exp 0/0", id_byp_a, id_byp_b); end
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_ex_valid got %0d exp 0", ex_valid); end
        rst = 1'b0;
        set_issue(5, 0, 1, 0, 0, 0, 1); tick();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL post_rst_ex_valid got %0d exp 1", ex_valid); end
        checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL post_rst_fwd_a got %0d exp 0", fwd_a); end
    endtask

    task automatic test_alu_b2b();
        drain();
        set_issue(0, 0, 0, 0, 5, 1, 1);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_i0_stall got %0d exp 0", stall); end
        tick();
        set_issue(5, 6, 1, 1, 0, 0, 1);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_i1_stall got %0d exp 0", stall); end
        tick(); idle();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL alu_ex_valid got %0d exp 1", ex_valid); end
        checks++; if (fwd_a !== 2'd1) begin errors++; $display("FAIL alu_fwd_a got %0d exp 1", fwd_a); end
        checks++; if (fwd_b !== 2'd0) begin errors++; $display("FAIL alu_fwd_b got %0d exp 0", fwd_b); end
    endtask

    task automatic test_load_use();
        drain();
        set_issue(0, 0, 0, 0, 7, 1, 2); tick();
        set_issue(1, 7, 1, 1, 0, 0, 1);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall1 got %0d exp 1", stall); end
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %0d exp 0", ex_valid); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall2 got %0d exp 0", stall); end
        tick(); idle();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL lu_ex_valid got %0d exp 1", ex_valid); end
        checks++; if (fwd_b !== 2'd2) begin errors++; $display("FAIL lu_fwd_b got %0d exp 2", fwd_b); end
        checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL lu_fwd_a got %0d exp 0", fwd_a); end
    endtask

    task automatic test_priority();
        drain();
        set_issue(0, 0, 0, 0, 4, 1, 1); tick();
        set_issue(0, 0, 0, 0, 4, 1, 1); tick();
        set_issue(4, 0, 1, 0, 0, 0, 1); tick(); idle();
        checks++; if (fwd_a !== 2'd1) begin errors++; $display("FAIL prio_fwd_a got %0d exp 1", fwd_a); end
        drain();
        set_issue(0, 0, 0, 0, 9, 1, 1); tick();
        set_issue(0, 0, 0, 0, 10, 1, 1); tick();
        set_issue(0, 0, 0, 0, 11, 1, 1); tick();
        set_issue(9, 0, 1, 0, 0, 0, 1);
        checks++; if (id_byp_a !== 1'b1) begin errors++; $display("FAIL dist_byp_a got %0d exp 1", id_byp_a); end
        checks++; if (id_byp_b !== 1'b0) begin errors++; $display("FAIL dist_byp_b got %0d exp 0", id_byp_b); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL dist_stall got %0d exp 0", stall); end
        tick(); idle();
        checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL dist_fwd_a got %0d exp 0", fwd_a); end
    endtask

    task automatic test_x0_use();
        drain();
        set_issue(0, 0, 0, 0, 0, 1, 2); tick();
        set_issue(0, 0, 1, 0, 0, 0, 1);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall got %0d exp 0", stall); end
        tick(); idle();
        checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL x0_fwd_a got %0d exp 0", fwd_a); end
        drain();
        set_issue(0, 0, 0, 0, 8, 1, 2); tick();
        set_issue(2, 8, 1, 0, 0, 0, 1);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL use_stall got %0d exp 0", stall); end
        tick(); idle();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL use_ex_valid got %0d exp 1", ex_valid); end
        checks++; if (fwd_b !== 2'd0) begin errors++; $display("FAIL use_fwd_b got %0d exp 0", fwd_b); end
    endtask

    task automatic test_clamp();
        drain();
        set_issue(0, 0, 0, 0, 14, 1, 3); tick();
        set_issue(14, 0, 1, 0, 0, 0, 1);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL clamp_stall1 got %0d exp 1", stall); end
        tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL clamp_stall2 got %0d exp 0", stall); end
        tick(); idle();
        checks++; if (fwd_a !== 2'd2) begin errors++; $display("FAIL clamp_fwd_a got %0d exp 2", fwd_a); end
    endtask

    task automatic test_flush();
        drain();
        set_issue(0, 0, 0, 0, 3, 1, 2); tick();
        flush = 1'b1;
        set_issue(3, 0, 1, 0, 3, 1, 1);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %0d exp 0", stall); end
        tick(); flush = 1'b0;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_ex_valid got %0d exp 0", ex_valid); end
        set_issue(3, 0, 1, 0, 0, 0, 1);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_cons_stall got %0d exp 0", stall); end
        tick(); idle();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL flush_cons_valid got %0d exp 1", ex_valid); end
        checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL flush_fwd_a got %0d exp 0", fwd_a); end
    endtask

    task automatic test_hold();
        drain();
        set_issue(0, 0, 0, 0, 12, 1, 1); tick();
        set_issue(12, 0, 1, 0, 13, 1, 1); tick();
        hold = 1'b1; flush = 1'b1;
        set_issue(13, 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL hold_ex_valid[%0d] got %0d exp 1", i, ex_valid); end
            checks++; if (fwd_a !== 2'd1 || fwd_b !== 2'd0) begin errors++; $display("FAIL hold_fwd[%0d] got %0d/%0d exp 1/0", i, fwd_a, fwd_b); end
        end
        hold = 1'b0; flush = 1'b0;
        set_issue(12, 13, 1, 1, 0, 0, 1);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hold_rel_stall got %0d exp 0", stall); end
        tick(); idle();
        checks++; if (fwd_a !== 2'd2) begin errors++; $display("FAIL hold_rel_fwd_a got %0d exp 2", fwd_a); end
        checks++; if (fwd_b !== 2'd1) begin errors++; $display("FAIL hold_rel_fwd_b got %0d exp 1", fwd_b); end
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_alu_b2b();
        test_load_use();
        test_priority();
        test_x0_use();
        test_clamp();
        test_flush();
        test_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
